// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader, memory and fetch stage.
// Holds the loader state encoding and the memory word/address widths.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes LSB first into a 32-bit word.
// word/word_ready present the completed word combinationally on the accepting cycle of byte 4.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [1:0]        byte_cnt_r;
  logic [WORD_W-1:0] shift_r;

  // New byte enters the top lane so the first byte ends up in bits [7:0]
  always_comb begin
    word       = {in_data, shift_r[WORD_W-1:BYTE_W]};
    word_ready = accept && (byte_cnt_r == 2'd3);
  end

  // Byte counter and shift register; the counter wraps 3->0 on each completed word
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= {WORD_W{1'b0}};
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= {WORD_W{1'b0}};
    end else if (accept) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      shift_r    <= word;
    end else begin
      byte_cnt_r <= byte_cnt_r;
      shift_r    <= shift_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: reads a 32-bit word count then that many little-endian words from a
// byte stream and writes them to consecutive instruction-memory addresses while stalling the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int             DEPTH     = 32,
  parameter int             AW        = ADDR_W,
  parameter logic [AW-1:0]  BASE_ADDR = {AW{1'b0}}
)
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AW-1:0]     mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_r;
  logic [CW-1:0]     word_cnt_r;
  logic [WORD_W-1:0] count_r;

  logic              accept_s;
  logic              clear_s;
  logic              last_word_s;
  logic [WORD_W-1:0] word_s;
  logic              word_ready_s;
  logic [AW-1:0]     waddr_s;

  // Handshake, restart qualification and address/last-word decode
  always_comb begin
    accept_s    = in_valid && in_ready;
    clear_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    last_word_s = (WORD_W'(word_cnt_r) + 32'd1) == count_r;
    waddr_s     = BASE_ADDR + AW'(word_cnt_r);
  end

  imem_loader_byte_packer u_packer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (clear_s),
    .accept     (accept_s),
    .in_data    (in_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // Loader FSM with registered handshake, memory strobe and status outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= {CW{1'b0}};
      count_r    <= {WORD_W{1'b0}};
      in_ready   <= 1'b0;
      mem_waddr  <= BASE_ADDR;
      mem_wdata  <= {WORD_W{1'b0}};
      mem_we     <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= ST_HDR;
            cpu_hold   <= 1'b1;
            error      <= 1'b0;
            in_ready   <= 1'b1;
            word_cnt_r <= {CW{1'b0}};
          end
        end
        ST_HDR: begin
          if (word_ready_s) begin
            count_r <= word_s;
            if (word_s == 32'd0) begin
              state_r  <= ST_DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else if (word_s > 32'(DEPTH)) begin
              state_r  <= ST_ERR;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              error    <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_ready_s) begin
            state_r   <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_waddr <= waddr_s;
            mem_wdata <= word_s;
          end
        end
        ST_WRITE: begin
          mem_we     <= 1'b0;
          word_cnt_r <= word_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_word_s) begin
            state_r  <= ST_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state_r  <= ST_DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes into a queue,
// and a negedge monitor pops and compares every memory write strobe.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mem_model [0:63];

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(32), .AW(32), .BASE_ADDR(32'd0)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue
  always @(negedge clock) begin
    logic [63:0] e;
    if (resetn) begin
      if (done) done_cnt++;
      if (mem_we) begin
        check("in_ready_low_on_write", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_waddr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", mem_waddr, e[63:32]);
          check("write_data", mem_wdata, e[31:0]);
        end
        mem_model[mem_waddr[5:0]] = mem_wdata;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !taken; i++) begin
      if (in_ready) taken = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!taken) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got in_ready=0 for 40 cycles expected acceptance of %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 40 && done_cnt < target; i++) begin
      @(posedge clock); #1;
    end
    check(name, done_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
    check({tag, "_mem_waddr"}, mem_waddr,         32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"},      {31'd0, done},     32'd0);
    check({tag, "_error"},     {31'd0, error},    32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clock); #1;

    // 1: two-word load
    pulse_start();
    check("t1_cpu_hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("t1_in_ready_in_hdr", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({32'd0, 32'h002000B3});
    exp_q.push_back({32'd1, 32'h40120133});
    send_word(32'd2, 0);
    send_word(32'h002000B3, 0);
    send_word(32'h40120133, 0);
    wait_done(1, "t1_done_count");
    check("t1_cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
    check("t1_in_ready_in_done", {31'd0, in_ready}, 32'd0);
    check("t1_queue_drained", exp_q.size(), 32'd0);
    repeat (3) begin @(posedge clock); #1; end
    check("t1_done_single_pulse", done_cnt, 32'd1);

    // 2: zero-length load goes straight to DONE
    pulse_start();
    send_word(32'd0, 0);
    wait_done(2, "t2_done_count");
    check("t2_cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
    check("t2_error_clear", {31'd0, error}, 32'd0);

    // 3: oversize count -> sticky error, cleared by the next start
    pulse_start();
    send_word(32'd33, 0);
    repeat (2) begin @(posedge clock); #1; end
    check("t3_error_set", {31'd0, error}, 32'd1);
    check("t3_cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
    check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("t3_no_done", done_cnt, 32'd2);
    pulse_start();
    check("t3_error_cleared", {31'd0, error}, 32'd0);
    check("t3_cpu_hold_again", {31'd0, cpu_hold}, 32'd1);
    exp_q.push_back({32'd0, 32'hCAFEF00D});
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    wait_done(3, "t3_done_count");

    // 4: three words with random in_valid gaps
    pulse_start();
    exp_q.push_back({32'd0, 32'h03020100});
    exp_q.push_back({32'd1, 32'h07060504});
    exp_q.push_back({32'd2, 32'h0B0A0908});
    send_word(32'd3, 2);
    send_word(32'h03020100, 3);
    send_word(32'h07060504, 3);
    send_word(32'h0B0A0908, 3);
    wait_done(4, "t4_done_count");
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // 5: start pulses mid-DATA and during WRITE are ignored
    pulse_start();
    exp_q.push_back({32'd0, 32'hA5A55A5A});
    exp_q.push_back({32'd1, 32'h12345678});
    send_word(32'd2, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    pulse_start();
    check("t5_cpu_hold_mid_data", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    pulse_start();
    send_word(32'h12345678, 0);
    wait_done(5, "t5_done_count");
    check("t5_queue_drained", exp_q.size(), 32'd0);

    // 6: reset after one and a half words
    pulse_start();
    exp_q.push_back({32'd0, 32'h11223344});
    send_word(32'd2, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    check("t6_queue_drained", exp_q.size(), 32'd0);
    check("t6_word0_kept", mem_model[0], 32'h11223344);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    exp_q.push_back({32'd0, 32'hEFBEADDE});
    send_word(32'd1, 0);
    send_word(32'hEFBEADDE, 0);
    wait_done(6, "t6_done_count");
    check("t6_fresh_word0", mem_model[0], 32'hEFBEADDE);
    check("t6_queue_drained_final", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
